// File: rtl/fetch_prefetch_queue.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | fetch_prefetch_queue: sequential instruction prefetch with an in-order |
// | PC/instruction queue, redirect flush and stale-response discard.       |
// | Optional perf counters enabled by macro FETCH_PERF_EN.                 |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module fetch_prefetch_queue #(
    parameter int          DEPTH           = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instrD,
    output logic [31:0] PCD,
    input  logic        instr_ready
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_flush_cnt,
    output logic [31:0] perf_starve_cnt
`endif
);

    localparam int          c_PTR_W   = $clog2(DEPTH);
    localparam int          c_CNT_W   = $clog2(DEPTH + 1);
    localparam int          c_OUT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [31:0] c_DEPTH   = 32'(DEPTH);
    localparam logic [31:0] c_MAX_OUT = 32'(MAX_OUTSTANDING);
    localparam logic [31:0] c_NOP     = 32'h0000_0013;
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [c_OUT_W-1:0] c_OUT_ONE = c_OUT_W'(1);

    logic [31:0]        r_instrQ [DEPTH];
    logic [31:0]        r_pcQ    [DEPTH];
    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;
    logic [c_CNT_W-1:0] r_count;
    logic [c_OUT_W-1:0] r_live;
    logic [c_OUT_W-1:0] r_discard;
    logic [31:0]        r_fetchPc;
    logic [31:0]        r_rspPc;
    logic [31:0]        r_lastPcD;

    logic [31:0]        w_queueCredit;
    logic [31:0]        w_inFlight;
    logic               w_grant;
    logic               w_keep;
    logic               w_drop;
    logic               w_push;
    logic               w_pop;
    logic [31:0]        w_redirPc;
    logic [c_OUT_W-1:0] w_flushSum;
    logic [c_OUT_W-1:0] w_flushDiscard;
    logic               w_unusedPcLsbs;

    assign w_queueCredit = 32'(r_count) + 32'(r_live);
    assign w_inFlight    = 32'(r_live) + 32'(r_discard);

    // Counting live requests against queue space means every kept response has a slot.
    assign imem_req  = rst && !redirect && (w_queueCredit < c_DEPTH) && (w_inFlight < c_MAX_OUT);
    assign imem_addr = r_fetchPc;

    assign w_grant = imem_req && imem_gnt;
    assign w_drop  = imem_rvalid && (r_discard != '0);
    assign w_keep  = imem_rvalid && (r_discard == '0) && (r_live != '0);
    assign w_push  = w_keep && !redirect;

    assign instr_valid = (r_count != '0);
    assign w_pop       = instr_valid && instr_ready && !redirect;
    assign instrD      = instr_valid ? r_instrQ[r_head] : c_NOP;
    assign PCD         = instr_valid ? r_pcQ[r_head] : r_lastPcD;

    assign w_redirPc      = {redirect_pc[31:2], 2'b00};
    assign w_unusedPcLsbs = ^redirect_pc[1:0];

    // live+discard never exceeds MAX_OUTSTANDING, so the sum fits the counter width.
    assign w_flushSum     = r_discard + r_live;
    assign w_flushDiscard = (imem_rvalid && (w_flushSum != '0)) ? (w_flushSum - c_OUT_ONE) : w_flushSum;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_live    <= '0;
            r_discard <= '0;
            r_fetchPc <= RESET_PC;
            r_rspPc   <= RESET_PC;
            r_lastPcD <= '0;
        end else begin
            r_lastPcD <= PCD;
            if (redirect) begin
                r_head    <= '0;
                r_tail    <= '0;
                r_count   <= '0;
                r_live    <= '0;
                r_discard <= w_flushDiscard;
                r_fetchPc <= w_redirPc;
                r_rspPc   <= w_redirPc;
            end else begin
                if (w_grant) begin
                    r_fetchPc <= r_fetchPc + 32'd4;
                end
                if (w_push) begin
                    r_tail  <= r_tail + c_PTR_ONE;
                    r_rspPc <= r_rspPc + 32'd4;
                end
                if (w_pop) begin
                    r_head <= r_head + c_PTR_ONE;
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + c_CNT_ONE;
                end else if (w_pop && !w_push) begin
                    r_count <= r_count - c_CNT_ONE;
                end
                if (w_grant && !w_keep) begin
                    r_live <= r_live + c_OUT_ONE;
                end else if (w_keep && !w_grant) begin
                    r_live <= r_live - c_OUT_ONE;
                end
                if (w_drop) begin
                    r_discard <= r_discard - c_OUT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_instrQ[r_tail] <= imem_rdata;
            r_pcQ[r_tail]    <= r_rspPc;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] r_flushCnt;
    logic [31:0] r_starveCnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_flushCnt  <= '0;
            r_starveCnt <= '0;
        end else begin
            if (redirect) begin
                r_flushCnt <= r_flushCnt + 32'd1;
            end
            if (!instr_valid) begin
                r_starveCnt <= r_starveCnt + 32'd1;
            end
        end
    end

    assign perf_flush_cnt  = r_flushCnt;
    assign perf_starve_cnt = r_starveCnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_prefetch_queue.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_fetch_prefetch_queue: bench for fetch_prefetch_queue with an        |
// | in-order memory model and a PC/instruction scoreboard.                 |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_fetch_prefetch_queue;

    localparam logic [31:0] c_NOP      = 32'h0000_0013;
    localparam logic [31:0] c_RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        instr_valid;
    logic [31:0] instrD;
    logic [31:0] PCD;
    logic        instr_ready = 1'b0;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_flush_cnt;
    logic [31:0] perf_starve_cnt;
`endif

    always #5 clk = ~clk;

    fetch_prefetch_queue #(
        .DEPTH(4), .MAX_OUTSTANDING(2), .RESET_PC(c_RESET_PC)
    ) dut (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instrD(instrD), .PCD(PCD), .instr_ready(instr_ready)
`ifdef FETCH_PERF_EN
        , .perf_flush_cnt(perf_flush_cnt), .perf_starve_cnt(perf_starve_cnt)
`endif
    );

    typedef struct { logic [31:0] addr; int cyc; bit stale; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
    typedef struct { bit gnt; bit ready; bit expReq; logic [31:0] expAddr; bit expValid; logic [31:0] expPcd; } vec_t;

    req_t        pend[$];
    exp_t        sb[$];
    int          nVec = 0;
    int          nMis = 0;
    int          cycNum = 0;
    bit          rvalidEn = 1'b1;
    bit          popSeen;
    logic [31:0] popPc;
    logic        sReq;
    logic        sValid;
    logic [31:0] sAddr;
    logic [31:0] sPcd;

    function automatic logic [31:0] memData(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cycNum);
        end
    endtask

    // One clock: drive at the falling edge, sample, update the model for the coming rising edge.
    task automatic cycle(input bit gnt, input bit ready, input bit redir = 1'b0, input logic [31:0] rpc = 32'h0);
        exp_t e;
        req_t r;
        @(negedge clk);
        imem_gnt    = gnt;
        instr_ready = ready;
        redirect    = redir;
        redirect_pc = rpc;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        if (rvalidEn && pend.size() != 0 && pend[0].cyc < cycNum) begin
            imem_rvalid = 1'b1;
            imem_rdata  = memData(pend[0].addr);
        end
        #1;
        sReq = imem_req; sValid = instr_valid; sAddr = imem_addr; sPcd = PCD;
        check("instr_valid", {31'b0, instr_valid}, {31'b0, sb.size() != 0});
        if (redir) check("req_during_redirect", {31'b0, imem_req}, 32'd0);
        popSeen = 1'b0;
        if (instr_valid && ready && !redir && sb.size() != 0) begin
            popSeen = 1'b1;
            popPc   = PCD;
            e = sb.pop_front();
            check("pop_pc", PCD, e.pc);
            check("pop_instr", instrD, e.instr);
        end
        if (redir) sb.delete();
        if (imem_rvalid) begin
            r = pend.pop_front();
            if (!r.stale && !redir) sb.push_back('{r.addr, memData(r.addr)});
        end
        if (redir) foreach (pend[i]) pend[i].stale = 1'b1;
        if (imem_req && gnt) pend.push_back('{imem_addr, cycNum, 1'b0});
        cycNum++;
        @(posedge clk);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b0; redirect = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
        instr_ready = 1'b0; imem_rdata = '0; redirect_pc = '0;
        #1;
        check("rst_imem_req", {31'b0, imem_req}, 32'd0);
        check("rst_imem_addr", imem_addr, c_RESET_PC);
        check("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_instrD", instrD, c_NOP);
        check("rst_PCD", PCD, 32'd0);
        pend.delete();
        sb.delete();
        rvalidEn = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic waitFirstPop(input string name, input logic [31:0] expPc);
        bit found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle(1'b1, 1'b1);
            if (popSeen) begin
                found = 1'b1;
                check(name, popPc, expPc);
            end
        end
        if (!found) begin
            nVec++; nMis++;
            $display("FAIL %s: no instruction within 20 cycles, expected PC 0x%08h", name, expPc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        vecs[0] = '{1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h0};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 32'h04, 1'b0, 32'h0};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h0};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h4};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h8};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 32'h14, 1'b1, 32'hC};

        // Streaming after reset with 1-cycle memory latency.
        doReset();
        for (int i = 0; i < 6; i++) begin
            cycle(vecs[i].gnt, vecs[i].ready);
            check("stream_req", {31'b0, sReq}, {31'b0, vecs[i].expReq});
            check("stream_addr", sAddr, vecs[i].expAddr);
            check("stream_valid", {31'b0, sValid}, {31'b0, vecs[i].expValid});
            check("stream_pcd", sPcd, vecs[i].expPcd);
        end

        // Decode stalled: queue fills, request drops at full credit, then drains in order.
        doReset();
        for (int c = 0; c < 8; c++) begin
            cycle(1'b1, 1'b0);
            check("fill_req", {31'b0, sReq}, (c < 4) ? 32'd1 : 32'd0);
            check("fill_pcd", sPcd, 32'd0);
        end
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, 1'b1);
            check("drain_popped", {31'b0, popSeen}, 32'd1);
            check("drain_pc", sPcd, 32'(k * 4));
        end

        // Redirect with two requests outstanding: both responses discarded.
        doReset();
        rvalidEn = 1'b0;
        cycle(1'b1, 1'b1, 1'b1, 32'h10);
        cycle(1'b1, 1'b1);
        check("outst_addr0", sAddr, 32'h10);
        cycle(1'b1, 1'b1);
        check("outst_addr1", sAddr, 32'h14);
        cycle(1'b1, 1'b1, 1'b1, 32'h100);
        rvalidEn = 1'b1;
        waitFirstPop("redirect_first_pc", 32'h100);
        repeat (4) cycle(1'b1, 1'b1);

        // Redirect to an unaligned target while a response arrives in the same cycle.
        doReset();
        cycle(1'b1, 1'b1);
        rvalidEn = 1'b0;
        cycle(1'b1, 1'b1);
        rvalidEn = 1'b1;
        cycle(1'b1, 1'b1, 1'b1, 32'h203);
        cycle(1'b1, 1'b1);
        check("redir_rv_req", {31'b0, sReq}, 32'd1);
        check("redir_rv_addr", sAddr, 32'h200);
        cycle(1'b1, 1'b1);
        check("redir_rv_credit_req", {31'b0, sReq}, 32'd1);
        check("redir_rv_addr2", sAddr, 32'h204);
        waitFirstPop("redir_rv_first_pc", 32'h200);
        repeat (4) cycle(1'b1, 1'b1);

        // Grant withheld: address holds until accepted.
        doReset();
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b1);
        for (int c = 0; c < 3; c++) begin
            cycle(1'b0, 1'b1);
            check("nognt_req", {31'b0, sReq}, 32'd1);
            check("nognt_addr", sAddr, 32'h8);
        end
        cycle(1'b1, 1'b1);
        check("gnt_addr", sAddr, 32'h8);
        cycle(1'b1, 1'b1);
        check("post_gnt_addr", sAddr, 32'hC);

        // Reset with three entries queued and one request in flight.
        doReset();
        for (int c = 0; c < 4; c++) cycle(1'b1, 1'b0);
        check("prereset_valid", {31'b0, sValid}, 32'd1);
        doReset();
        cycle(1'b1, 1'b1);
        check("restart_req", {31'b0, sReq}, 32'd1);
        check("restart_addr", sAddr, c_RESET_PC);
        cycle(1'b1, 1'b1);
        check("restart_addr1", sAddr, c_RESET_PC + 32'd4);
        repeat (4) cycle(1'b1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_prefetch_queue.md
Name: fetch_prefetch_queue

Overview:
- Instruction prefetch buffer between the instruction-memory port and the decode stage.
- Issues sequential word fetches ahead of decode and tracks in-flight requests.
- Buffers returned instructions with their PCs in an in-order queue; presents the queue head to decode under a valid/ready handshake.
- Flushes and redirects on an execute-stage branch (PCsrcE / PCplusImmE). In-flight responses fetched before the redirect are discarded.

Parameters:
- DEPTH, 4, queue entries (power of two, >=2).
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered memory requests (>=1).
- RESET_PC, 32'h00000000, first fetch address after reset.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- redirect  input  1  branch taken in execute (PCsrcE).
- redirect_pc  input  32  branch target (PCplusImmE); bits [1:0] ignored.
- imem_req  output  1  fetch request valid.
- imem_addr  output  32  fetch word address, always 4-byte aligned.
- imem_gnt  input  1  request accepted this cycle when imem_req=1.
- imem_rvalid  input  1  response valid; responses return in request order.
- imem_rdata  input  32  response instruction.
- instr_valid  output  1  queue head valid to decode.
- instrD  output  32  head instruction.
- PCD  output  32  head PC.
- instr_ready  input  1  decode accepts head (low = stall).

Behaviour:
- Reset (rst=0, asynchronous):
  - Queue empty; outstanding=0; discard=0.
  - fetch_pc=RESET_PC and rsp_pc=RESET_PC.
  - Outputs: imem_req=0, imem_addr=RESET_PC, instr_valid=0, instrD=32'h00000013 (NOP), PCD=0.
- Counters:
  - count = queued entries.
  - live = outstanding requests whose responses will be kept.
  - discard = outstanding requests whose responses will be dropped.
- imem_req = !redirect && (count+live) < DEPTH && (live+discard) < MAX_OUTSTANDING. This credit check guarantees the queue never overflows.
- imem_addr = fetch_pc. It holds stable while imem_req=1 and imem_gnt=0, unless a redirect occurs.
- Grant (imem_req && imem_gnt): fetch_pc += 4 (wraps modulo 2^32); live++.
- Response (imem_rvalid):
  - If discard>0: drop the data, discard--.
  - Otherwise: push {imem_rdata, rsp_pc}, rsp_pc += 4, live--.
  - A response with live=0 and discard=0 is a protocol error and is ignored.
- Pushed data appears on instr_valid/instrD/PCD on the cycle after imem_rvalid. There is no bypass, so the minimum response-to-decode latency is 1 cycle.
- Pop: instr_valid && instr_ready advances the head. Push and pop in the same cycle leaves count unchanged, including at full.
- instr_valid = (count != 0). When empty, instrD=NOP and PCD holds its last value.
- Redirect (redirect=1), evaluated in one cycle:
  - Queue cleared; a same-cycle pop is ignored.
  - fetch_pc = rsp_pc = {redirect_pc[31:2],2'b00}.
  - discard = discard + live − (imem_rvalid ? 1 : 0), saturating at 0; live=0.
  - imem_req is forced 0 this cycle, so the bus may see the request withdrawn.
  - The first new request issues the next cycle if credits allow.
- Back-to-back redirects: the last one wins; discard accumulates correctly.
- Reset mid-transaction: all counts clear. External memory must also be reset, because no stale-response tracking survives reset.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined:
  - Adds output ports perf_flush_cnt [31:0] and perf_starve_cnt [31:0], both reset to 0.
  - perf_flush_cnt increments on each redirect cycle.
  - perf_starve_cnt increments each cycle instr_valid=0 and rst=1.
  - Both wrap at 2^32.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset release, imem_gnt=1, 1-cycle rvalid latency, instr_ready=1:
  - first imem_addr=0x0;
  - instr_valid rises 2 cycles after the first grant with PCD=0x0;
  - then PCD=0x4, 0x8, 0xC on consecutive cycles.
- instr_ready=0 held:
  - queue fills to DEPTH=4 (PCD stays 0x0);
  - imem_req drops once count+live=4;
  - no overflow;
  - on release, 4 pops with PCs 0x0..0xC in order.
- Two requests outstanding (0x10, 0x14), then redirect to 0x100:
  - both responses dropped;
  - next valid output PCD=0x100;
  - no 0x10/0x14 ever presented.
- Redirect to 0x203 while imem_rvalid=1 in the same cycle:
  - that response dropped;
  - imem_addr becomes 0x200;
  - discard ends at 0 after the remaining responses.
- imem_gnt=0 for 3 cycles with imem_req=1: imem_addr stays at 0x8 throughout; fetch_pc advances only after the grant.
- rst asserted mid-stream with queue at 3 entries: outputs immediately return to reset values; after release, fetch restarts at RESET_PC.
